uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the parametrised UART transmitter.
// Parity selectors match the PARITY_MODE parameter values.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Line levels of the framing bits; the line idles at the stop level.
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy and a head word that is always visible on dout.
// Simultaneous push and pop leave the level unchanged and keep order.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; only pointers and occupancy are control state.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered valid/ready input, LSB-first framing with
// optional parity and one or two stop bits, registered serial output.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 2500,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          line_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_ODD && PARITY_MODE != PAR_EVEN) ||
            STOP_BITS < 1 || STOP_BITS > 2 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    localparam int BAUD_W = $clog2(CLK_DIV);
    // Wide enough for DATA_BITS-1 (max 8) and the stop-bit index.
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_nxt;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 par_bit;
    logic                 par_nxt;
    logic                 line_nxt;
    logic                 baud_end;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == PAR_ODD) ? ~^d : ^d;
    endfunction

    assign fifo_push = tx_valid & ~fifo_full;
    assign tx_ready  = ~fifo_full;
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE) | (fifo_level != '0);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par_bit;
        fifo_pop  = 1'b0;
        line_nxt  = STOP_LVL;

        if (state != IDLE) begin
            baud_nxt = baud_end ? '0 : baud_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                fifo_pop = ~fifo_empty;
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // bit_cnt counts stop periods so a two-stop frame needs no second counter
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                        fifo_pop  = ~fifo_empty;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Popping from IDLE or from the end of STOP both launch a new frame.
        if (fifo_pop) begin
            state_nxt = START;
            baud_nxt  = '0;
            bit_nxt   = '0;
            shift_nxt = fifo_dout;
            par_nxt   = frame_parity(fifo_dout);
        end

        case (state_nxt)
            START:   line_nxt = START_LVL;
            DATA:    line_nxt = shift_nxt[0];
            PARITY:  line_nxt = par_nxt;
            default: line_nxt = STOP_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            line_tx  <= STOP_LVL;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            line_tx  <= line_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift   <= shift_nxt;
        par_bit <= par_nxt;
    end

endmodule
